// File: rtl/bcd_upcounter_chain_pkg.sv
// Shared constants for the cascaded BCD up-counter.
// State encodings, digit width and default mm:ss limits.
package bcd_upcounter_chain_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_ZERO = '0;

  localparam logic [BCD_W-1:0] DEF_LIMIT0 = 4'd9;
  localparam logic [BCD_W-1:0] DEF_LIMIT1 = 4'd5;
  localparam logic [BCD_W-1:0] DEF_LIMIT2 = 4'd9;
  localparam logic [BCD_W-1:0] DEF_LIMIT3 = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_upcounter_chain_digit.sv
// One BCD digit of the up-counter chain.
// Out-of-range loads saturate to the digit limit.
module bcd_up_digit
  import bcd_upcounter_chain_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic [BCD_W-1:0] limit,
  output logic [BCD_W-1:0] value,
  output logic             at_limit
);

  logic [BCD_W-1:0] ld_sat;

  assign at_limit = (value == limit);
  assign ld_sat   = (ld_val > limit) ? limit : ld_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= BCD_ZERO;
    end else if (clr) begin
      value <= BCD_ZERO;
    end else if (ld) begin
      value <= ld_sat;
    end else if (inc) begin
      value <= at_limit ? BCD_ZERO : value + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_upcounter_chain.sv
// Four-digit cascaded BCD up-counter with run/pause/done control.
// Default limits give a 00:00..59:59 stopwatch.
module bcd_upcounter_chain
  import bcd_upcounter_chain_pkg::*;
#(
  parameter logic [BCD_W-1:0] LIMIT0      = DEF_LIMIT0,
  parameter logic [BCD_W-1:0] LIMIT1      = DEF_LIMIT1,
  parameter logic [BCD_W-1:0] LIMIT2      = DEF_LIMIT2,
  parameter logic [BCD_W-1:0] LIMIT3      = DEF_LIMIT3,
  parameter bit               STOP_AT_MAX = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] value,
  output logic        carry,
  output logic        running,
  output logic        done
);

  localparam logic [15:0] LIMITS = {LIMIT3, LIMIT2, LIMIT1, LIMIT0};

  state_t     state;
  state_t     state_nx;
  logic [3:0] at_lim;
  logic [3:0] inc;
  logic       count_en;
  logic       full;
  logic       hold;
  logic       load_ok;
  logic       ld;
  logic       wrap;

  assign count_en = (state == ST_RUN) && tick;
  assign full     = &at_lim;
  assign hold     = full && STOP_AT_MAX;
  assign load_ok  = load && (state != ST_RUN);
  assign ld       = load_ok && !clear;
  assign wrap     = count_en && full && !STOP_AT_MAX && !clear;

  // Ripple enable: digit i steps when all lower digits sit at their limit.
  always_comb begin
    logic chain;
    inc   = '0;
    chain = count_en && !hold;
    for (int i = 0; i < 4; i++) begin
      inc[i] = chain;
      chain  = chain && at_lim[i];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_digit
    bcd_up_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc[g]),
      .clr      (clear),
      .ld       (ld),
      .ld_val   (load_value[4*g +: 4]),
      .limit    (LIMITS[4*g +: 4]),
      .value    (value[4*g +: 4]),
      .at_limit (at_lim[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      carry <= 1'b0;
    end else begin
      state <= state_nx;
      carry <= wrap;
    end
  end

  // A terminal tick outranks a coincident pause.
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = ST_IDLE;
    end else if (load_ok) begin
      state_nx = ST_PAUSE;
    end else begin
      unique case (state)
        ST_IDLE, ST_PAUSE: begin
          if (start && !pause) state_nx = ST_RUN;
        end
        ST_RUN: begin
          if (count_en && hold) state_nx = ST_DONE;
          else if (pause)       state_nx = ST_PAUSE;
        end
        ST_DONE: state_nx = ST_DONE;
      endcase
    end
  end

  always_comb begin
    running = 1'b0;
    done    = 1'b0;
    unique case (state)
      ST_RUN:  running = 1'b1;
      ST_DONE: done    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bcd_upcounter_chain.sv
// Self-checking bench: two counters (hold and wrap variants)
// against an ordinal-number reference model.
module tb_bcd_upcounter_chain;

  localparam int MAXN = 10 * 6 * 10 * 6 - 1;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, start, pause, clear, load;
  logic [15:0] load_value;
  logic [15:0] value_s, value_w;
  logic        carry_s, carry_w;
  logic        running_s, running_w;
  logic        done_s, done_w;

  int n_cmp = 0;
  int n_bad = 0;

  int mn [2];
  int ms [2];
  bit mc [2];

  always #5 clk = ~clk;

  bcd_upcounter_chain #(.STOP_AT_MAX(1'b1)) u_stop (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .pause(pause), .clear(clear), .load(load),
    .load_value(load_value), .value(value_s), .carry(carry_s),
    .running(running_s), .done(done_s)
  );

  bcd_upcounter_chain #(.STOP_AT_MAX(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .pause(pause), .clear(clear), .load(load),
    .load_value(load_value), .value(value_w), .carry(carry_w),
    .running(running_w), .done(done_w)
  );

  function automatic int radix(int i);
    return (i % 2 == 0) ? 10 : 6;
  endfunction

  function automatic logic [15:0] to_bcd(int n);
    logic [15:0] v = '0;
    int r = n;
    for (int i = 0; i < 4; i++) begin
      v[4*i +: 4] = 4'(r % radix(i));
      r = r / radix(i);
    end
    return v;
  endfunction

  function automatic int from_bcd_sat(logic [15:0] v);
    int n = 0;
    int d;
    for (int i = 3; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > radix(i) - 1) d = radix(i) - 1;
      n = n * radix(i) + d;
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0;
      ms[k] = M_IDLE;
      mc[k] = 1'b0;
    end
  endtask

  task automatic model_step(int k, bit stop);
    mc[k] = 1'b0;
    if (clear) begin
      ms[k] = M_IDLE;
      mn[k] = 0;
    end else if (load && ms[k] != M_RUN) begin
      mn[k] = from_bcd_sat(load_value);
      ms[k] = M_PAUSE;
    end else if (ms[k] == M_IDLE || ms[k] == M_PAUSE) begin
      if (start && !pause) ms[k] = M_RUN;
    end else if (ms[k] == M_RUN) begin
      if (tick) begin
        if (mn[k] < MAXN) mn[k]++;
        else if (stop) ms[k] = M_DONE;
        else begin
          mn[k] = 0;
          mc[k] = 1'b1;
        end
      end
      if (ms[k] == M_RUN && pause) ms[k] = M_PAUSE;
    end
  endtask

  task automatic check_all();
    chk("val_stop", value_s, to_bcd(mn[0]));
    chk("carry_stop", 16'(carry_s), 16'(mc[0]));
    chk("run_stop", 16'(running_s), 16'(ms[0] == M_RUN));
    chk("done_stop", 16'(done_s), 16'(ms[0] == M_DONE));
    chk("val_wrap", value_w, to_bcd(mn[1]));
    chk("carry_wrap", 16'(carry_w), 16'(mc[1]));
    chk("run_wrap", 16'(running_w), 16'(ms[1] == M_RUN));
    chk("done_wrap", 16'(done_w), 16'(ms[1] == M_DONE));
  endtask

  task automatic step(bit t, bit s, bit p, bit c, bit l,
                      logic [15:0] lv);
    tick = t; start = s; pause = p; clear = c; load = l;
    load_value = lv;
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    tick = 0; start = 0; pause = 0; clear = 0; load = 0;
    load_value = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_val", value_s, 16'h0000);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // 60 ticks from zero
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) step(1, 0, 0, 0, 0, 0);
    chk("t60_val", value_s, 16'h0100);
    chk("t60_run", 16'(running_s), 16'd1);

    // Terminal count, both variants
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 16'h5958);
    chk("ld_pause", 16'(running_s), 16'd0);
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("max_stop", value_s, 16'h5959);
    chk("max_done", 16'(done_s), 16'd1);
    chk("wrap_val", value_w, 16'h0000);
    chk("wrap_carry", 16'(carry_w), 16'd1);
    step(1, 1, 0, 0, 0, 0);
    chk("hold_stop", value_s, 16'h5959);
    chk("hold_done", 16'(done_s), 16'd1);
    chk("wrap_next", value_w, 16'h0001);
    chk("wrap_nocarry", 16'(carry_w), 16'd0);

    // tick together with pause
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 16'h0009);
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("tp_val", value_s, 16'h0010);
    chk("tp_run", 16'(running_s), 16'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    chk("tp_hold", value_w, 16'h0010);

    // saturating load, ignored load in RUN, clear with tick
    step(0, 0, 0, 0, 1, 16'hFC7A);
    chk("sat_val", value_s, 16'h5959);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 16'h0300);
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 16'h1234);
    chk("ldrun_val", value_s, 16'h0301);
    step(1, 0, 0, 1, 0, 0);
    chk("clr_val", value_w, 16'h0000);
    chk("clr_carry", 16'(carry_w), 16'd0);

    // asynchronous reset mid-count
    step(0, 0, 0, 0, 1, 16'h0426);
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("pre_rst", value_s, 16'h0427);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_val", value_s, 16'h0000);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] lv;
      lv = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      step(1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 19) == 0,
           lv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
